adder_unit_arbiter: RTL

- Shares the single register port of the adder unit (weight memory / membrane potential) between NUM_REQ requesters. Requester 0 is the RISC-V core; the others are DMA or spike-event engines.
- Round-robin arbitration and a valid/ready request handshake.
- Sequences read/write strobes into the adder unit and returns read data to the winning requester.
- Counts and flags spike_detected events for the RISC-V side.

---
 rtl/adder_unit_pkg.sv | 25 ++
 rtl/adder_unit_arbiter_rr_arbiter.sv | 38 +++
 rtl/adder_unit_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/adder_unit_pkg.sv
// Shared types and helpers for the adder unit register-port arbiter.
package adder_unit_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} au_arb_state_e;

  localparam int AU_ADDR_W = 6;
  localparam int AU_DATA_W = 16;
  localparam int MAX_REQ   = 8;

  // First set bit of valid at or above ptr, wrapping at n; returns ptr if none set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int win;
    int idx;
    win = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/adder_unit_arbiter_rr_arbiter.sv
// Combinational round-robin pick with a registered priority pointer.
module rr_arbiter
  import adder_unit_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               upd_en,
  input  logic [IDX_W-1:0]   upd_idx,
  output logic               grant_any,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;

  assign valid_ext = MAX_REQ'(req_valid);
  assign grant_any = |req_valid;
  assign grant_idx = IDX_W'(rr_pick(valid_ext, int'(ptr_q), NUM_REQ));

  // Wrap explicitly so a non-power-of-two NUM_REQ never reaches an unused index.
  always_comb begin
    ptr_d = ptr_q;
    if (upd_en) begin
      if (upd_idx == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                ptr_d = upd_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_unit_arbiter.sv
// Shares the adder unit register port among NUM_REQ requesters and counts spike events.
module adder_unit_arbiter
  import adder_unit_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = AU_ADDR_W,
  parameter int DATA_WIDTH = AU_DATA_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          au_read,
  output logic                          au_write,
  output logic [ADDR_WIDTH-1:0]         au_addr,
  output logic [DATA_WIDTH-1:0]         au_data_in,
  input  logic [DATA_WIDTH-1:0]         au_data_out,
  input  logic                          au_spike_detected,
  input  logic                          spike_clear,
  output logic [CNT_WIDTH-1:0]          spike_count,
  output logic                          spike_irq
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [IDX_W-1:0]      win;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  au_arb_state_e         state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  grant_any, upd_en;
  logic [IDX_W-1:0]      grant_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .upd_en    (upd_en),
    .upd_idx   (cmd_q.win),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  // Grant is only offered out of reset, so nothing is accepted while held in reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && reset && grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    upd_en      = 1'b0;
    case (state_q)
      IDLE: if (grant_any) begin
        cmd_d.win   = grant_idx;
        cmd_d.write = req_write[grant_idx];
        cmd_d.addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_d.wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (cmd_q.write) begin
          rsp_valid_d[cmd_q.win] = 1'b1;
          state_d                = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_valid_d[cmd_q.win] = 1'b1;
        rsp_rdata_d            = au_data_out;
        state_d                = RESP;
      end
      RESP: begin
        upd_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign au_write   = (state_q == ISSUE) &&  cmd_q.write;
  assign au_read    = (state_q == ISSUE) && !cmd_q.write;
  assign au_addr    = (state_q == ISSUE) ? cmd_q.addr : '0;
  assign au_data_in = au_write ? cmd_q.wdata : '0;

  logic                 spike_d_q, spike_irq_q, spike_irq_d, rise;
  logic [CNT_WIDTH-1:0] spike_cnt_q, spike_cnt_d;

  assign rise = au_spike_detected & ~spike_d_q;

  // A clear coinciding with a rise keeps that rise, leaving the count at one.
  always_comb begin
    spike_irq_d = rise;
    spike_cnt_d = spike_cnt_q;
    if (spike_clear)                   spike_cnt_d = rise ? CNT_WIDTH'(1) : '0;
    else if (rise && ~&spike_cnt_q)    spike_cnt_d = spike_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spike_d_q   <= 1'b0;
      spike_irq_q <= 1'b0;
      spike_cnt_q <= '0;
    end else begin
      spike_d_q   <= au_spike_detected;
      spike_irq_q <= spike_irq_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  assign spike_count = spike_cnt_q;
  assign spike_irq   = spike_irq_q;

endmodule
